// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_e;

  localparam int TIMEOUT_CYC_DEF = 65535;
endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared by reset.
module bit_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one byte at a time from N_REQ requesters
// into a single UART transmitter, with a per-character abort timer.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_clear_req,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     timeout_err
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;
  logic             active_q, active_d;
  logic             to_err_q, to_err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             clr_prev_q;

  logic busy_s, clr_s, clr_rise;
  logic found;
  logic [GW-1:0] pick;

  bit_sync2 u_busy_sync (.clk(clk), .rst(rst), .d(tx_busy),      .q(busy_s));
  bit_sync2 u_clr_sync  (.clk(clk), .rst(rst), .d(tx_clear_req), .q(clr_s));

  assign clr_rise = clr_s & ~clr_prev_q;

  // Search upward from the requester after the last one served, wrapping.
  always_comb begin : arb_pick
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = last_q;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    tx_start_d  = tx_start_q;
    tx_data_d   = tx_data_q;
    grant_d     = grant_q;
    last_d      = last_q;
    to_err_d    = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d           = START;
          grant_d           = pick;
          tx_data_d         = req_data[{pick, 3'b000} +: 8];
          req_ready_d[pick] = 1'b1;
          tx_start_d        = 1'b1;
          cnt_d             = '0;
        end
      end
      START, WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        // Abort wins over any handshake progress in the same cycle.
        if (cnt_d == CW'(TIMEOUT_CYC)) begin
          state_d    = IDLE;
          tx_start_d = 1'b0;
          tx_data_d  = 8'h00;
          to_err_d   = 1'b1;
          last_d     = grant_q;
          cnt_d      = '0;
        end else if (state_q == START && busy_s) begin
          state_d    = WAIT_DONE;
          tx_start_d = 1'b0;
        end else if (state_q == WAIT_DONE && clr_rise) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d   = IDLE;
        last_d    = grant_q;
        tx_data_d = 8'h00;
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      grant_q     <= '0;
      last_q      <= GW'(N_REQ - 1);
      active_q    <= 1'b0;
      to_err_q    <= 1'b0;
      cnt_q       <= '0;
      clr_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      active_q    <= active_d;
      to_err_q    <= to_err_d;
      cnt_q       <= cnt_d;
      clr_prev_q  <= clr_s;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign active      = active_q;
  assign timeout_err = to_err_q;
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535, max clk cycles per character before abort.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, N_REQ, requester i has a byte pending.
REQ-006 SHALL have port req_data, input, 8*N_REQ, byte of requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_ready, output, N_REQ, one-cycle accept pulse to the granted requester.
REQ-008 SHALL have port tx_start, output, 1, start request to the UART transmitter.
REQ-009 SHALL have port tx_data, output, 8, byte to the UART transmitter.
REQ-010 SHALL have port tx_busy, input, 1, transmitter busy (asynchronous to clk).
REQ-011 SHALL have port tx_clear_req, input, 1, transmitter done strobe (asynchronous to clk).
REQ-012 SHALL have port grant_id, output, clog2(N_REQ), index of the requester currently served.
REQ-013 SHALL have port active, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have port timeout_err, output, 1, one-cycle pulse on character abort.

Function
REQ-015 SHALL synchronize tx_busy and tx_clear_req through two flops each before use; raw inputs drive no logic.
REQ-016 SHALL implement FSM states IDLE, START, WAIT_DONE, GAP.
REQ-017 IDLE: if any req_valid, SHALL pick the first set bit searching upward (with wrap) from last_grant+1, then at the next edge latch that byte, set grant_id, and enter START.
REQ-018 SHALL assert req_ready[grant_id] for exactly the first START cycle; no other req_ready bit SHALL ever be high.
REQ-019 Requesters SHALL hold req_valid and req_data stable until req_ready; a valid dropped before grant SHALL be ignored without error.
REQ-020 START: tx_start=1 and tx_data=latched byte; SHALL go to WAIT_DONE on the first cycle synced busy=1.
REQ-021 WAIT_DONE: tx_start=0 and tx_data held; SHALL go to GAP on a rising edge of synced tx_clear_req.
REQ-022 GAP: SHALL last one cycle, set last_grant=grant_id, and return to IDLE.
REQ-023 A cycle counter SHALL clear on entry to START and increment in START and WAIT_DONE.
REQ-024 When the counter reaches TIMEOUT_CYC, the FSM SHALL return to IDLE, drop tx_start, pulse timeout_err, and update last_grant; the byte is lost.
REQ-025 Latency: from req_valid high in IDLE to tx_start high SHALL be exactly 1 clk.
REQ-026 Only one byte SHALL be in flight; back-to-back requests from the same requester SHALL alternate with all other pending requesters.
REQ-027 tx_data SHALL be 0 in IDLE; grant_id SHALL hold its last value in IDLE.

Reset
REQ-028 rst high SHALL asynchronously force state IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, timeout_err=0, counter=0, synchronizers=0, and last_grant=N_REQ-1, so requester 0 wins first.
REQ-029 rst mid-character SHALL abandon the byte with no req_ready re-pulse; the UART completes it independently.

Structure
REQ-030 Package uart_arb_pkg SHALL hold the FSM state enum (2-bit) and the default TIMEOUT_CYC constant.
REQ-031 A sub-module bit_sync2 (two-flop synchronizer, async reset to 0) SHALL be instantiated twice.

Verification
REQ-032 Single request: req_valid=4'b0001, req_data[7:0]=8'h41 -> req_ready=4'b0001 for 1 cycle; tx_start high 1 clk later with tx_data=8'h41; after the UART model's clear strobe, active falls; the UART model receives 0x41.
REQ-033 Contention: all four valid with bytes 0x10,0x11,0x12,0x13 held continuously -> transmit order 0x10,0x11,0x12,0x13,0x10...
REQ-034 Fairness: req 2 re-asserts immediately after each accept while req 0 is pending -> grants alternate 2,0,2,0.
REQ-035 Timeout: TIMEOUT_CYC=100, tx_busy tied 0 -> tx_start drops and timeout_err pulses once at cycle 100 after START; the next requester is then served.
REQ-036 Reset mid-operation: rst pulsed during WAIT_DONE -> all outputs 0 next sample; a subsequent request from req 0 is granted first.
REQ-037 Protocol check: tx_start never high outside START; req_ready is always one-hot or zero.
